// File: rtl/cam_capture_wr.sv
// cam_capture_wr: synchronises an OV7670-style byte stream and writes packed RGB565 pixels into the frame buffer.
module cam_capture_wr #(
  parameter int AW    = 17,
  parameter int DW    = 16,
  parameter int IMG_W = 320,
  parameter int IMG_H = 240
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cap_en,
  input  logic          cam_pclk,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic [7:0]    cam_data,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic          frame_done,
  output logic          overflow
);
  localparam int NPIX = IMG_W * IMG_H;
  typedef enum logic [1:0] {S_WAIT_VS, S_WAIT_START, S_HI, S_LO} state_t;
  logic [2:0]      pclk_q;
  logic [1:0]      vs_q, href_q;
  logic [7:0]      dat1_q, dat2_q;
  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d, addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [7:0]      hi_q, hi_d;
  logic            we_q, we_d, done_q, done_d, ovf_q, ovf_d;
  logic            smp, vs, href;
  assign smp  = pclk_q[1] & ~pclk_q[2];
  assign vs   = vs_q[1];
  assign href = href_q[1];
  // Vsync edges are judged by level: the state already records the previous level.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    if (smp) begin
      case (state_q)
        S_WAIT_VS: state_d = vs ? S_WAIT_START : S_WAIT_VS;
        S_WAIT_START:
          if (!vs) begin
            ptr_d   = '0;
            ovf_d   = cap_en ? 1'b0 : ovf_q;
            state_d = cap_en ? S_HI : S_WAIT_VS;
          end
        S_HI:
          if (vs) begin
            done_d  = 1'b1;
            state_d = S_WAIT_START;
          end else if (href) begin
            hi_d    = dat2_q;
            state_d = S_LO;
          end
        S_LO:
          if (vs) begin
            done_d  = 1'b1;
            state_d = S_WAIT_START;
          end else begin
            state_d = S_HI;
            if (href && ptr_q == AW'(NPIX)) ovf_d = 1'b1;
            else if (href) begin
              we_d   = 1'b1;
              addr_d = ptr_q;
              data_d = {hi_q, dat2_q};
              ptr_d  = ptr_q + AW'(1);
            end
          end
        default: state_d = S_WAIT_VS;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk_q  <= '0;
      vs_q    <= '0;
      href_q  <= '0;
      dat1_q  <= '0;
      dat2_q  <= '0;
      state_q <= S_WAIT_VS;
      ptr_q   <= '0;
      hi_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pclk_q  <= {pclk_q[1:0], cam_pclk};
      vs_q    <= {vs_q[0], cam_vsync};
      href_q  <= {href_q[0], cam_href};
      dat1_q  <= cam_data;
      dat2_q  <= dat1_q;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end
  assign addr_in    = addr_q;
  assign data_in    = data_q;
  assign regwrite   = we_q;
  assign frame_done = done_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_cam_capture_wr.sv
// tb_cam_capture_wr: camera-stream bench with a frame-level pixel scoreboard, on a reduced 8x6 image.
module tb_cam_capture_wr;
  localparam int AW = 17, IMG_W = 8, IMG_H = 6, NPIX = IMG_W * IMG_H;
  logic clk = 0, rst_n = 0, cap_en = 0, cam_pclk = 0, cam_vsync = 0, cam_href = 0;
  logic [7:0] cam_data = 0;
  logic [AW-1:0] addr_in;
  logic [15:0] data_in;
  logic regwrite, frame_done, overflow;

  cam_capture_wr #(.AW(AW), .DW(16), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .addr_in(addr_in), .data_in(data_in),
    .regwrite(regwrite), .frame_done(frame_done), .overflow(overflow));

  always #5 clk = ~clk;

  typedef struct {logic [AW-1:0] a; logic [15:0] d;} wr_t;
  typedef struct {bit en; int lines; int bpl; int nwr; bit ovf; int last;} vec_t;
  wr_t exp_q[$], got[$];
  logic [7:0] fixed[$];
  int lens[$];
  bit vs_href = 0;
  int tests = 0, fails = 0, done_cnt = 0, ptr_m = 0;
  bit ovf_m = 0;
  vec_t v[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : mon
    wr_t w, e;
    if (frame_done) done_cnt++;
    if (rst_n && regwrite) begin
      w.a = addr_in;
      w.d = data_in;
      got.push_back(w);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0d data %h want none", addr_in, data_in);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 64'(addr_in), 64'(e.a));
        chk("write_data", 64'(data_in), 64'(e.d));
      end
    end
  end

  task automatic cyc(input bit vs, input bit hr, input logic [7:0] d);
    @(negedge clk);
    cam_vsync = vs; cam_href = hr; cam_data = d;
    repeat (2) @(negedge clk);
    cam_pclk = 1;
    repeat (2) @(negedge clk);
    cam_pclk = 0;
  endtask

  task automatic mdl_pixel(input logic [15:0] d);
    wr_t e;
    if (ptr_m < NPIX) begin
      e.a = AW'(ptr_m);
      e.d = d;
      exp_q.push_back(e);
      ptr_m++;
    end else ovf_m = 1;
  endtask

  task automatic frame(input bit en);
    logic [7:0] b, hi;
    int d0;
    cap_en = en;
    d0 = done_cnt;
    got.delete();
    hi = 0;
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    if (en) begin ptr_m = 0; ovf_m = 0; end
    foreach (lens[l]) begin
      for (int i = 0; i < lens[l]; i++) begin
        b = fixed.size() != 0 ? fixed.pop_front() : 8'($urandom);
        if (en && (i % 2 == 1)) mdl_pixel({hi, b});
        cyc(0, 1, b);
        if (i % 2 == 0) hi = b;
      end
      if (!(vs_href && l == lens.size() - 1)) begin cyc(0, 0, 0); cyc(0, 0, 0); end
    end
    cyc(1, vs_href, 8'h5A);
    repeat (6) @(negedge clk);
    chk("frame_done_count", 64'(done_cnt - d0), en ? 64'd1 : 64'd0);
    chk("pending_writes", 64'(exp_q.size()), 64'd0);
    chk("overflow", 64'(overflow), 64'(ovf_m));
  endtask

  initial begin
    v[0] = '{1, 6, 16, 48, 0, 47};
    v[1] = '{1, 7, 16, 48, 1, 47};
    v[2] = '{0, 2, 16, 0, 1, -1};
    v[3] = '{1, 1, 4, 2, 0, 1};
    v[4] = '{1, 3, 5, 6, 0, 5};
    v[5] = '{1, 1, 1, 0, 0, -1};
    // T1: reset values, then bytes before any vsync
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({addr_in, data_in, regwrite, frame_done, overflow}), 64'd0);
    rst_n = 1;
    cap_en = 1;
    for (int i = 0; i < 6; i++) cyc(0, 1, 8'($urandom));
    repeat (6) @(negedge clk);
    chk("no_write_before_vsync", 64'(got.size()), 64'd0);
    chk("idle_outputs", 64'({addr_in, data_in, regwrite, frame_done, overflow}), 64'd0);
    // T2
    lens = '{4};
    fixed = '{8'hF8, 8'h00, 8'h07, 8'hE0};
    frame(1);
    chk("t2_count", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      chk("t2_addr0", 64'(got[0].a), 64'd0); chk("t2_data0", 64'(got[0].d), 64'hF800);
      chk("t2_addr1", 64'(got[1].a), 64'd1); chk("t2_data1", 64'(got[1].d), 64'h07E0);
    end
    // T4: odd byte at line end is dropped
    lens = '{3, 2};
    fixed = '{8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22};
    frame(1);
    chk("t4_count", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      chk("t4_addr0", 64'(got[0].a), 64'd0); chk("t4_data0", 64'(got[0].d), 64'hAABB);
      chk("t4_addr1", 64'(got[1].a), 64'd1); chk("t4_data1", 64'(got[1].d), 64'h1122);
    end
    // vsync rising together with a low byte: no write
    lens = '{1};
    vs_href = 1;
    frame(1);
    vs_href = 0;
    chk("vsync_wins", 64'(got.size()), 64'd0);
    // Table: full frame, overflow, disabled frame, overflow clear, odd lines, single byte
    foreach (v[k]) begin
      lens.delete();
      repeat (v[k].lines) lens.push_back(v[k].bpl);
      frame(v[k].en);
      chk("vec_writes", 64'(got.size()), 64'(v[k].nwr));
      chk("vec_overflow", 64'(overflow), 64'(v[k].ovf));
      if (v[k].last >= 0 && got.size() > 0) chk("vec_last_addr", 64'(got[got.size()-1].a), 64'(v[k].last));
    end
    // T6: reset mid-line
    cap_en = 1;
    got.delete();
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    ptr_m = 0; ovf_m = 0;
    cyc(0, 1, 8'h12);
    mdl_pixel(16'h1234);
    cyc(0, 1, 8'h34);
    cyc(0, 1, 8'h56);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("reset_mid_line", 64'({addr_in, data_in, regwrite, frame_done, overflow}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    exp_q.delete(); got.delete(); ptr_m = 0; ovf_m = 0;
    for (int i = 0; i < 6; i++) cyc(0, 1, 8'($urandom));
    repeat (6) @(negedge clk);
    chk("t6_no_partial_frame", 64'(got.size()), 64'd0);
    lens = '{4};
    frame(1);
    chk("t6_count", 64'(got.size()), 64'd2);
    if (got.size() > 0) chk("t6_first_addr", 64'(got[0].a), 64'd0);
    // Random frames against the scoreboard
    for (int r = 0; r < 20; r++) begin
      lens.delete();
      repeat ($urandom_range(1, 8)) lens.push_back($urandom_range(0, 20));
      frame($urandom_range(0, 3) != 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
